// File: rtl/sequential_logic_pkg.sv
// ============================================================================
// Module      : sequential_logic_pkg
// Description : Shared operation encodings for sequential_logic_vector.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package sequential_logic_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_UP   = 3'b100,
        MODE_DN   = 3'b101,
        MODE_ROL  = 3'b110,
        MODE_ROR  = 3'b111
    } mode_e;

endpackage

`default_nettype wire

// File: rtl/slv_next_state.sv
// ============================================================================
// Module      : slv_next_state
// Description : Combinational next-state selection for the vector register.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module slv_next_state
    import sequential_logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  q,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  next_q,
    output logic              next_sout,
    output logic              sout_load
);

    // sout_load marks the shift/rotate modes; every other mode keeps SOUT.
    always_comb begin
        next_q    = q;
        next_sout = 1'b0;
        sout_load = 1'b0;
        case (mode)
            MODE_HOLD: next_q = q;
            MODE_LOAD: next_q = d;
            MODE_SHL: begin
                next_q    = {q[WIDTH-2:0], sin};
                next_sout = q[WIDTH-1];
                sout_load = 1'b1;
            end
            MODE_SHR: begin
                next_q    = {sin, q[WIDTH-1:1]};
                next_sout = q[0];
                sout_load = 1'b1;
            end
            MODE_UP:  next_q = q + WIDTH'(1);
            MODE_DN:  next_q = q - WIDTH'(1);
            MODE_ROL: begin
                next_q    = {q[WIDTH-2:0], q[WIDTH-1]};
                next_sout = q[WIDTH-1];
                sout_load = 1'b1;
            end
            MODE_ROR: begin
                next_q    = {q[0], q[WIDTH-1:1]};
                next_sout = q[0];
                sout_load = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sequential_logic_vector.sv
// ============================================================================
// Module      : sequential_logic_vector
// Description : Multi-mode register: load, shift, rotate, up/down count.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sequential_logic_vector
    import sequential_logic_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RST_VALUE = '0,
    parameter logic [WIDTH-1:0] SD_VALUE  = '1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              SLn,
    input  logic [MODE_W-1:0] MODE,
    input  logic [WIDTH-1:0]  D,
    input  logic              SIN,
    output logic [WIDTH-1:0]  Q,
    output logic              SOUT,
    output logic              TC
);

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic [WIDTH-1:0] w_next_q;
    logic             w_next_sout;
    logic             w_sout_load;
    logic             w_at_max;
    logic             w_at_zero;

    slv_next_state #(
        .WIDTH     (WIDTH)
    ) u_next_state (
        .q         (r_q),
        .d         (D),
        .sin       (SIN),
        .mode      (MODE),
        .next_q    (w_next_q),
        .next_sout (w_next_sout),
        .sout_load (w_sout_load)
    );

    // Priority: reset, then synchronous SD load, then enabled mode operation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q    <= RST_VALUE;
            r_sout <= 1'b0;
        end else if (!SLn) begin
            r_q    <= SD_VALUE;
        end else if (EN) begin
            r_q    <= w_next_q;
            if (w_sout_load) begin
                r_sout <= w_next_sout;
            end
        end
    end

    assign w_at_max  = &r_q;
    assign w_at_zero = ~|r_q;

    assign TC = EN && !RST && SLn &&
                (((MODE == MODE_UP) && w_at_max) ||
                 ((MODE == MODE_DN) && w_at_zero));

    assign Q    = r_q;
    assign SOUT = r_sout;

endmodule

`default_nettype wire

// File: tb/tb_sequential_logic_vector.sv
// ============================================================================
// Module      : tb_sequential_logic_vector
// Description : Directed and randomized checks against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sequential_logic_vector;

    localparam int         WIDTH = 8;
    localparam logic [7:0] C_RST = 8'h5A;
    localparam logic [7:0] C_SD  = 8'hFF;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       sln = 1'b1;
    logic [2:0] mode = 3'd0;
    logic [7:0] d   = 8'd0;
    logic       sin = 1'b0;
    logic [7:0] q;
    logic       sout;
    logic       tc;

    int errors = 0;
    int checks = 0;

    // Reference state held as plain integers
    int m_q    = 0;
    int m_sout = 0;
    logic tc_pre;

    always #5 clk = ~clk;

    sequential_logic_vector #(
        .WIDTH     (WIDTH),
        .RST_VALUE (C_RST),
        .SD_VALUE  (C_SD)
    ) dut (
        .CLK  (clk),
        .RST  (rst),
        .EN   (en),
        .SLn  (sln),
        .MODE (mode),
        .D    (d),
        .SIN  (sin),
        .Q    (q),
        .SOUT (sout),
        .TC   (tc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_tc(input int r, input int e, input int s, input int md, input int cur);
        if (r != 0 || e == 0 || s == 0) return 0;
        if (md == 4 && cur == 255) return 1;
        if (md == 5 && cur == 0) return 1;
        return 0;
    endfunction

    task automatic model_step(input int r, input int e, input int s, input int md, input int dd, input int si);
        if (r != 0) begin
            m_q = int'(C_RST); m_sout = 0;
        end else if (s == 0) begin
            m_q = int'(C_SD);
        end else if (e != 0) begin
            case (md)
                1: m_q = dd;
                2: begin m_sout = m_q / 128; m_q = (m_q * 2 + si) % 256; end
                3: begin m_sout = m_q % 2;  m_q = m_q / 2 + si * 128; end
                4: m_q = (m_q + 1) % 256;
                5: m_q = (m_q + 255) % 256;
                6: begin m_sout = m_q / 128; m_q = (m_q * 2 + m_q / 128) % 256; end
                7: begin m_sout = m_q % 2;  m_q = m_q / 2 + (m_q % 2) * 128; end
                default: ;
            endcase
        end
    endtask

    // Drive on the falling edge, check TC before the rising edge, Q/SOUT after.
    task automatic step(input logic r, input logic e, input logic s, input logic [2:0] md,
                        input logic [7:0] dd, input logic si);
        @(negedge clk);
        rst = r; en = e; sln = s; mode = md; d = dd; sin = si;
        #1;
        tc_pre = tc;
        chk("tc_model", {31'd0, tc}, model_tc(r, e, s, md, m_q));
        @(posedge clk);
        model_step(r, e, s, md, dd, si);
        #1;
        chk("q_model", {24'd0, q}, m_q);
        chk("sout_model", {31'd0, sout}, m_sout);
    endtask

    initial begin
        // Reset wins over an enabled count
        step(1, 1, 1, 3'b100, 8'h00, 0);
        chk("rst_q", {24'd0, q}, 32'h5A);
        chk("rst_sout", {31'd0, sout}, 0);
        chk("rst_tc", {31'd0, tc_pre}, 0);

        // Count-up wrap through all-ones
        step(0, 1, 1, 3'b001, 8'hFE, 0);
        step(0, 1, 1, 3'b100, 8'h00, 0);
        chk("up_ff", {24'd0, q}, 32'hFF);
        chk("up_tc_fe", {31'd0, tc_pre}, 0);
        step(0, 1, 1, 3'b100, 8'h00, 0);
        chk("up_00", {24'd0, q}, 32'h00);
        chk("up_tc_ff", {31'd0, tc_pre}, 1);
        step(0, 1, 1, 3'b100, 8'h00, 0);
        chk("up_01", {24'd0, q}, 32'h01);
        chk("up_tc_00", {31'd0, tc_pre}, 0);

        // Shift left then shift right
        step(0, 1, 1, 3'b001, 8'b1000_0001, 0);
        step(0, 1, 1, 3'b010, 8'h00, 1);
        chk("shl_q", {24'd0, q}, 32'h03);
        chk("shl_sout", {31'd0, sout}, 1);
        step(0, 1, 1, 3'b011, 8'h00, 0);
        chk("shr_q", {24'd0, q}, 32'h01);
        chk("shr_sout", {31'd0, sout}, 1);

        // Rotate right
        step(0, 1, 1, 3'b001, 8'h01, 0);
        step(0, 1, 1, 3'b111, 8'h00, 0);
        chk("ror_q", {24'd0, q}, 32'h80);
        chk("ror_sout", {31'd0, sout}, 1);

        // Count-down wrap from zero
        step(0, 1, 1, 3'b001, 8'h00, 0);
        step(0, 1, 1, 3'b101, 8'h00, 0);
        chk("dn_wrap", {24'd0, q}, 32'hFF);
        chk("dn_tc_00", {31'd0, tc_pre}, 1);

        // Priority of SD load and reset over MODE
        step(0, 1, 0, 3'b001, 8'h33, 0);
        chk("sln_q", {24'd0, q}, 32'hFF);
        step(1, 1, 0, 3'b001, 8'h33, 0);
        chk("rst_pri_q", {24'd0, q}, 32'h5A);

        // Hold with EN low
        step(0, 0, 1, 3'b100, 8'h00, 0);
        chk("hold_q", {24'd0, q}, 32'h5A);

        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
                 8'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sequential_logic_vector.md
SEQUENTIAL_LOGIC_VECTOR -- requirements
Module: sequential_logic_vector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits (legal values 2..32).
REQ-002 The block SHALL have parameter RST_VALUE, default 0, giving the WIDTH-bit value loaded by RST.
REQ-003 The block SHALL have parameter SD_VALUE, default all-ones, giving the WIDTH-bit value loaded by the synchronous load SLn.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port CLK, input, 1 bit: the only clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port RST, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port EN, input, 1 bit: clock enable for MODE operations.
REQ-008 The block SHALL have port SLn, input, 1 bit: active-low synchronous load of SD_VALUE.
REQ-009 The block SHALL have port MODE, input, 3 bits: operation select.
REQ-010 The block SHALL have port D, input, WIDTH bits: parallel load data.
REQ-011 The block SHALL have port SIN, input, 1 bit: serial input for shifts.
REQ-012 The block SHALL have port Q, output, WIDTH bits: registered state.
REQ-013 The block SHALL have port SOUT, output, 1 bit: registered bit shifted or rotated out.
REQ-014 The block SHALL have port TC, output, 1 bit: combinational terminal-count flag.

Function
REQ-015 The block SHALL apply this priority per rising CLK edge: RST, then SLn=0, then EN=1 with MODE, then hold.
REQ-016 The block SHALL, when EN=0 and no higher-priority event is active, hold Q and SOUT.
REQ-017 The block SHALL decode MODE as follows: 000 hold; 001 Q<=D; 010 shift left, Q<={Q[W-2:0],SIN}; 011 shift right, Q<={SIN,Q[W-1:1]}; 100 count up by 1; 101 count down by 1; 110 rotate left; 111 rotate right.
REQ-018 The block SHALL update SOUT only on shift or rotate: Q[W-1] before a left operation, Q[0] before a right operation.
REQ-019 The block SHALL leave SOUT unchanged for every other MODE, for SLn loads and for holds.
REQ-020 The block SHALL wrap counts modulo 2^WIDTH: all-ones+1 gives 0 and 0-1 gives all-ones, with no saturation.
REQ-021 The block SHALL drive TC=1 exactly when EN=1 and RST=0 and SLn=1 and either (MODE=100 and Q all-ones) or (MODE=101 and Q=0); otherwise TC=0.
REQ-022 The block SHALL give every operation a latency of one cycle: the result is visible on Q at the edge after the inputs are sampled.
REQ-023 The block SHALL, when SLn=0 and EN=1 occur together, load SD_VALUE and ignore MODE; SOUT holds.
REQ-024 The block SHALL treat the hold encoding MODE=000 with EN=1 as equivalent to EN=0.

Reset
REQ-025 The block SHALL, when RST=1 at a rising edge, set Q=RST_VALUE and SOUT=0 regardless of EN, SLn and MODE.
REQ-026 The block SHALL force TC=0 whenever RST=1.
REQ-027 The block SHALL let RST asserted mid-count or mid-shift discard the in-progress operation, so that no partial update occurs.
REQ-028 The block SHALL resume normal operation on the first edge after RST deasserts.
REQ-029 The block SHALL contain no asynchronous set, clear or load paths and no latches.

Structure
REQ-030 The block SHALL take the MODE encodings (MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_UP, MODE_DN, MODE_ROL, MODE_ROR) from the shared package sequential_logic_pkg.
REQ-031 The block SHALL implement next-state selection in one combinational sub-module, slv_next_state, with inputs Q, D, SIN and MODE and outputs next Q and next SOUT.
REQ-032 The block SHALL keep all flip-flops in the top module.

Verification
REQ-033 The bench SHALL check reset: WIDTH=8, RST_VALUE=8'h5A, RST=1 with EN=1, MODE=100 -> Q=8'h5A, SOUT=0, TC=0.
REQ-034 The bench SHALL check count-up wrap: Q=8'hFE, EN=1, MODE=100 for three edges -> Q=FF, then 00, then 01; TC=1 only while Q=FF.
REQ-035 The bench SHALL check shift left: Q=8'b1000_0001, MODE=010, SIN=1 -> Q=8'b0000_0011, SOUT=1; a following right shift with SIN=0 -> Q=8'b0000_0001, SOUT=1.
REQ-036 The bench SHALL check rotate right: Q=8'h01, MODE=111 -> Q=8'h80, SOUT=1.
REQ-037 The bench SHALL check priority: SLn=0, EN=1, MODE=001, D=8'h33 -> Q=SD_VALUE (8'hFF); the same with RST=1 -> Q=RST_VALUE.
REQ-038 The bench SHALL run 200 random cycles of RST, EN, SLn, MODE, D and SIN and compare Q, SOUT and TC against a reference model every cycle.
